// File: rtl/mips_dmem_ctrl_pkg.sv
// Shared types and helpers for the MIPS data-memory controller.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int unsigned DMEM_MAX_RD_LAT = 4;

  // Misaligned byte address, or word index beyond the array.
  function automatic logic dmem_fault(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction

endpackage

// File: rtl/mips_dmem_ctrl_if.sv
// Request/response bus between the MIPS core (master) and the data-memory controller (slave).
interface mips_dmem_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mips_dmem_ctrl_array.sv
// Word storage: byte-enabled synchronous write port, address-registered read port.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  ridx_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem_q[widx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    if (re_i) ridx_q <= ridx_i;
  end

  assign rdata_o = mem_q[ridx_q];

endmodule

// File: rtl/mips_dmem_ctrl.sv
// MIPS data-memory controller: valid/ready requests, configurable read latency, fault reporting.
// Define MIPS_DMEM_SCRUB_EN to clear the whole array after reset (busy high while scrubbing).
module mips_dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_dmem_ctrl_if.slave      bus,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LAT_W = $clog2(DMEM_MAX_RD_LAT);

  if ((RD_LAT < 1) || (RD_LAT > DMEM_MAX_RD_LAT) || (DATA_W % 8 != 0) ||
      (DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_param
    $error("mips_dmem_ctrl: illegal parameter combination");
  end

  dmem_state_t       state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              pend_we_q;
  logic              pend_err_q;

  logic              accept;
  logic              fault;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_widx;
  logic [DATA_W-1:0] arr_wdata;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_rdata;

  assign fault = dmem_fault(64'(bus.req_addr), DEPTH);

`ifdef MIPS_DMEM_SCRUB_EN
  logic [IDX_W-1:0]  scrub_q, scrub_d;
  logic              busy_q;
`endif

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    accept    = 1'b0;
    arr_we    = 1'b0;
    arr_widx  = bus.req_addr[IDX_W+1:2];
    arr_wdata = bus.req_wdata;
    arr_be    = bus.req_be;
`ifdef MIPS_DMEM_SCRUB_EN
    scrub_d   = scrub_q;
`endif
    case (state_q)
      INIT: begin
`ifdef MIPS_DMEM_SCRUB_EN
        arr_we    = 1'b1;
        arr_widx  = scrub_q;
        arr_wdata = '0;
        arr_be    = '1;
        scrub_d   = scrub_q + 1'b1;
        if (scrub_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          accept  = 1'b1;
          arr_we  = bus.req_we && !fault;
          lat_d   = LAT_W'(RD_LAT - 1);
          state_d = (bus.req_we || RD_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Leave one cycle early so RESP (and the registered pulse after it) lands on edge k+RD_LAT.
        lat_d = lat_q - 1'b1;
        if (lat_q <= LAT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .widx_i  (arr_widx),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .re_i    (accept),
    .ridx_i  (bus.req_addr[IDX_W+1:2]),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      lat_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      ready_q     <= (state_d == IDLE);
      rsp_valid_q <= (state_q == RESP);
      if (accept) begin
        pend_we_q  <= bus.req_we;
        pend_err_q <= fault;
      end
      if (state_q == RESP) begin
        rsp_err_q   <= pend_err_q;
        rsp_rdata_q <= (pend_we_q || pend_err_q) ? '0 : arr_rdata;
      end
    end
  end

`ifdef MIPS_DMEM_SCRUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      scrub_q <= scrub_d;
      busy_q  <= (state_d == INIT);
    end
  end

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Self-checking bench for mips_dmem_ctrl (DEPTH=16, RD_LAT=3) against a word-array reference model.
module tb_mips_dmem_ctrl;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned RD_LAT = 3;
`ifdef MIPS_DMEM_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif
  localparam int unsigned RELEASE_EDGES = SCRUB ? DEPTH : 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  mips_dmem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mips_dmem_ctrl #(
    .DATA_W (32),
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},     32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    check({tag, "_busy"},      32'(busy),          32'(SCRUB));
  endtask

  // Release reset and count edges until the controller becomes ready.
  task automatic release_and_scrub(input string tag);
    int n;
    int nbusy;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    nbusy = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.req_ready === 1'b1) break;
      if (busy === 1'b1) nbusy++;
    end
    check({tag, "_ready_edges"}, 32'(n), 32'(RELEASE_EDGES));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(RELEASE_EDGES - 1));
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic err,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 100), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid === 1'b1) break;
    end
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    @(posedge clk);
    #1;
    check("rsp_single", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic txn(input string tag, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, output logic [31:0] rd);
    logic err;
    int lat;
    bit exp_err;
    int unsigned idx;
    exp_err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    idx = (addr / 4) % DEPTH;
    do_txn(we, addr, wd, be, rd, err, lat);
    check({tag, "_lat"}, 32'(lat), we ? 32'd1 : 32'(RD_LAT));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!we) check({tag, "_rdata"}, rd, exp_err ? 32'd0 : ref_mem[idx]);
    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic init_contents();
`ifdef MIPS_DMEM_SCRUB_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      txn("fill", 1'b1, 32'(i * 4), $urandom, 4'hF, d);
    end
`endif
  endtask

  task automatic back_to_back();
    logic [31:0] addrs [3];
    int acc [3];
    int nacc;
    int npulse;
    bit prev_rv;
    bit dbl;
    bit rdy;
    bit rv;
    logic [31:0] rdat;
    addrs[0] = 32'h8;
    addrs[1] = 32'hC;
    addrs[2] = 32'h0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    nacc = 0;
    npulse = 0;
    prev_rv = 1'b0;
    dbl = 1'b0;
    @(negedge clk);
    bus.req_we    = 1'b0;
    bus.req_addr  = addrs[0];
    bus.req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rdy  = bus.req_ready;
      rv   = bus.rsp_valid;
      rdat = bus.rsp_rdata;
      if (rv && prev_rv) dbl = 1'b1;
      if (rv) begin
        if (npulse < 3)
          check($sformatf("b2b_rdata%0d", npulse), rdat, ref_mem[addrs[npulse] / 4]);
        npulse++;
      end
      prev_rv = rv;
      @(posedge clk);
      if (rdy && bus.req_valid && nacc < 3) begin
        acc[nacc] = c;
        nacc++;
      end
      #1;
      if (nacc >= 3) bus.req_valid = 1'b0;
      else bus.req_addr = addrs[nacc];
      @(negedge clk);
    end
    check("b2b_accepts",   32'(nacc),            32'd3);
    check("b2b_space01",   32'(acc[1] - acc[0]), 32'(RD_LAT + 1));
    check("b2b_space12",   32'(acc[2] - acc[1]), 32'(RD_LAT + 1));
    check("b2b_pulses",    32'(npulse),          32'd3);
    check("b2b_no_double", 32'(dbl),             32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int unsigned mode;
    bit saw;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    #12;
    check_reset_vals("por");
    release_and_scrub("por");
    init_contents();

    txn("rd0", 1'b0, 32'h0, 32'h0, 4'h0, rd);

    txn("wr8", 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd);
    txn("rd8", 1'b0, 32'h8, 32'h0, 4'h0, rd);
    check("rd8_value", rd, 32'hDEADBEEF);

    txn("wrC", 1'b1, 32'hC, 32'hAABBCCDD, 4'hF, rd);
    txn("wrC_be", 1'b1, 32'hC, 32'h11223344, 4'b0101, rd);
    txn("rdC", 1'b0, 32'hC, 32'h0, 4'h0, rd);
    check("rdC_value", rd, 32'hAA22CC44);

    txn("wr10_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd);
    txn("rd10", 1'b0, 32'h10, 32'h0, 4'h0, rd);

    txn("rd6_mis", 1'b0, 32'h6, 32'h0, 4'h0, rd);
    txn("wr40_oor", 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd);
    txn("rd0_after", 1'b0, 32'h0, 32'h0, 4'h0, rd);

    back_to_back();

    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(0, 9);
      if (mode < 7)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (mode < 9) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else               a = 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
      txn("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    // Reset while a read sits in WAIT.
    @(negedge clk);
    check("mid_pre_ready", 32'(bus.req_ready), 32'd1);
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h8;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) saw = 1'b1;
    end
    check("mid_no_rsp", 32'(saw), 32'd0);
    release_and_scrub("mid");
    init_contents();
    txn("post_rd8", 1'b0, 32'h8, 32'h0, 4'h0, rd);
    txn("post_rdC", 1'b0, 32'hC, 32'h0, 4'h0, rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_dmem_ctrl.md
# mips_dmem_ctrl

Parametrised data-memory controller for the MIPS datapath. It replaces the fixed 32-bit, 512-word, zero-latency data memory with a configurable array that adds:
- a valid/ready request handshake and a configurable read latency;
- byte-lane writes and address-fault reporting;
- a post-reset scrub engine.

The block sits between the ALU address/Readdata2 path and the MemtoReg mux. The core stalls on `req_ready`/`rsp_valid`.

## Interface
Parameters:
- `DATA_W`, 32, word width; multiple of 8.
- `ADDR_W`, 32, byte-address width.
- `DEPTH`, 512, number of words; power of two, ≥ 4.
- `RD_LAT`, 1, read latency in cycles; legal 1..4.

Ports:
- `clk` in 1: single clock. Everything is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `DATA_W`: write data.
- `req_be` in `DATA_W/8`: byte enables for writes; ignored on reads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out `DATA_W`: read data.
- `rsp_err` out 1: request faulted.
- `busy` out 1: scrub in progress.

## Operation
- States: `INIT`, `IDLE`, `WAIT`, `RESP`.
- Reset values: state `INIT`, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=1, scrub counter 0.
- `INIT`: writes 0 to word[scrub_cnt] each cycle and increments the counter. After word `DEPTH-1` it moves to `IDLE` and drops `busy`. Requests are ignored.
- `IDLE`: `req_ready`=1. A request is accepted on an edge where `req_valid`&`req_ready`. Address, `we` and fault status are registered at that edge.
- Fault: `req_addr[1:0]`≠0 (misaligned), or word index `req_addr>>2` ≥ `DEPTH` (out of range).
  - Faulted writes do not modify memory.
  - Faulted reads return `rsp_rdata`=0.
- Writes:
  - Performed at the accept edge. Only lanes with `req_be[i]`=1 update byte i.
  - `req_be`=0 is legal: memory is unchanged and a response is still issued.
  - Next state `RESP`.
- Reads: next state `WAIT` with latency counter = `RD_LAT-1`. The counter decrements each cycle; at 0 the next state is `RESP`. When `RD_LAT`=1, `WAIT` is skipped.
- `RESP`: `rsp_valid`=1 for exactly one cycle, then `IDLE`. `req_ready`=0 in `WAIT` and `RESP`.
- `rsp_rdata`/`rsp_err` change only when `rsp_valid` asserts and hold between responses.
- One outstanding request at a time. Request inputs are don't-care while `req_ready`=0.
- `rst_n` low mid-operation: immediate return to `INIT` with reset values. An in-flight write that was already accepted is retained until the scrub overwrites it.

## Timing
- Write accepted at edge k: `rsp_valid` high between edges k+1 and k+2.
- Read accepted at edge k: `rsp_valid` high between edges k+`RD_LAT` and k+`RD_LAT`+1.
- Earliest next accept:
  - after a write, edge k+2;
  - after a read, edge k+`RD_LAT`+1.
- Read data reflects all writes accepted at earlier edges (read-after-write coherent).
- Scrub: `busy` falls and `req_ready` rises `DEPTH` edges after `rst_n` deasserts.
- `req_ready` is registered; no combinational path from `req_valid` to `req_ready`.

## Configuration
- `MIPS_DMEM_SCRUB_EN` defined: behaviour as above; `INIT` clears the whole array.
- `MIPS_DMEM_SCRUB_EN` undefined:
  - `INIT` lasts one cycle; `busy` is tied 0;
  - `req_ready` rises at the first edge after reset release;
  - array contents after reset are undefined (no clear; suits FPGA block RAM).

## Structure
- Shared package `mips_mem_pkg` holds:
  - state enum `dmem_state_t`;
  - `DMEM_MAX_RD_LAT`=4;
  - fault-decode function `dmem_fault(addr, depth)`.
- One sub-module, `dmem_array`: storage with a byte-enabled synchronous write port and an address-registered read port. The controller FSM, latency counter and scrub counter live in `mips_dmem_ctrl`.
- Elaboration check: assert `RD_LAT` within 1..4, `DATA_W`%8==0 and `DEPTH` a power of two.

## Test plan
- Reset release with scrub on, `DEPTH`=16 → `busy`=1 for 16 cycles. Then `req_ready`=1 and a read of 0x0 returns 0 with `rsp_err`=0.
- Write 0xDEADBEEF to 0x8 with `req_be`=4'b1111, then read 0x8 with `RD_LAT`=3 → `rsp_valid` exactly 3 edges after the read accept, `rsp_rdata`=0xDEADBEEF.
- Write 0x11223344 with `req_be`=4'b0101 over a word holding 0xAABBCCDD → readback 0xAA22CC44.
- Read at 0x6 (misaligned), then write at 0x40 with `DEPTH`=16 (out of range) → both give `rsp_err`=1. A read of 0x0 afterwards shows memory unchanged.
- Back-to-back `req_valid` held high for 3 reads, `RD_LAT`=2 → accepts spaced 3 edges apart, each `rsp_valid` a single cycle.
- `rst_n` pulsed low during `WAIT` → `rsp_valid` never fires, all outputs return to reset values, and the scrub restarts from word 0.
